// File: rtl/n64_command_scheduler.sv
// Controller-side joybus sequencer: arms the receiver, decodes the console command,
// waits the turnaround gap and feeds response bytes to the transmitter.
module n64_command_scheduler #(
    parameter int unsigned RESP_DELAY = 100,
    parameter int unsigned TX_TIMEOUT = 5000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        rx_trigger,
    input  logic        rx_receiving,
    input  logic [7:0]  rx_command,
    output logic        tx_start,
    output logic [2:0]  tx_len,
    output logic [7:0]  tx_data,
    input  logic        tx_byte_req,
    input  logic        tx_busy,
    input  logic [31:0] pad_state,
    output logic        pad_latch,
    output logic [7:0]  last_cmd,
    output logic [15:0] cmd_count,
    output logic [7:0]  err_count
);

    localparam int unsigned CntMax = (RESP_DELAY > TX_TIMEOUT) ? RESP_DELAY : TX_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t DelayLast   = cnt_t'(RESP_DELAY - 1);
    localparam cnt_t TimeoutLast = cnt_t'(TX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitStart,
        StWaitDone,
        StDecode,
        StDelay,
        StSend
    } state_e;

    state_e           state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][7:0]  resp_q, resp_d;
    logic [2:0]       tx_len_q, tx_len_d;
    logic [7:0]       last_cmd_q, last_cmd_d;
    logic [15:0]      cmd_count_q, cmd_count_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_seen_q, busy_seen_d;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            resp_q      <= '0;
            tx_len_q    <= '0;
            last_cmd_q  <= '0;
            cmd_count_q <= '0;
            err_count_q <= '0;
            tx_start_q  <= 1'b0;
            busy_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            resp_q      <= resp_d;
            tx_len_q    <= tx_len_d;
            last_cmd_q  <= last_cmd_d;
            cmd_count_q <= cmd_count_d;
            err_count_q <= err_count_d;
            tx_start_q  <= tx_start_d;
            busy_seen_q <= busy_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        resp_d      = resp_q;
        tx_len_d    = tx_len_q;
        last_cmd_d  = last_cmd_q;
        cmd_count_d = cmd_count_q;
        err_count_d = err_count_q;
        tx_start_d  = 1'b0;
        busy_seen_d = busy_seen_q;

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StArm;
            end
            StArm: state_d = StWaitStart;
            StWaitStart: begin
                if (rx_receiving) state_d = StWaitDone;
            end
            StWaitDone: begin
                if (!rx_receiving) begin
                    last_cmd_d = rx_command;
                    state_d    = StDecode;
                end
            end
            StDecode: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = StDelay;
                case (last_cmd_q)
                    8'h00, 8'hFF: begin
                        resp_d   = {8'h00, 8'h02, 8'h00, 8'h05};
                        tx_len_d = 3'd3;
                    end
                    8'h01: begin
                        // Byte 0 goes out first and carries the MSB of the pad word.
                        resp_d   = {pad_state[7:0], pad_state[15:8],
                                    pad_state[23:16], pad_state[31:24]};
                        tx_len_d = 3'd4;
                    end
                    default: begin
                        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                        state_d = StArm;
                    end
                endcase
            end
            StDelay: begin
                if (cnt_q == DelayLast) begin
                    tx_start_d  = 1'b1;
                    cnt_d       = '0;
                    busy_seen_d = 1'b0;
                    state_d     = StSend;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StSend: begin
                cnt_d = cnt_q + cnt_t'(1);
                if (tx_busy) busy_seen_d = 1'b1;
                if (tx_byte_req && ({1'b0, idx_q} != (tx_len_q - 3'd1))) idx_d = idx_q + 2'd1;
                // A busy fall in the same cycle as timeout expiry counts as success.
                if (busy_seen_q && !tx_busy) begin
                    cmd_count_d = cmd_count_q + 16'd1;
                    state_d     = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_trigger = (state_q == StArm);
    assign pad_latch  = (state_q == StDecode) && (last_cmd_q == 8'h01);
    assign tx_start   = tx_start_q;
    assign tx_len     = tx_len_q;
    assign tx_data    = (state_q == StSend) ? resp_q[idx_q] : 8'h00;
    assign last_cmd   = last_cmd_q;
    assign cmd_count  = cmd_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_n64_command_scheduler.sv
// Randomized bench: plays console and transmitter, checks the scheduler against
// an expected transaction model (response bytes, latencies, counters).
module tb_n64_command_scheduler;

    localparam int unsigned RD = 5;
    localparam int unsigned TO = 40;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        rx_trigger;
    logic        rx_receiving;
    logic [7:0]  rx_command;
    logic        tx_start;
    logic [2:0]  tx_len;
    logic [7:0]  tx_data;
    logic        tx_byte_req;
    logic        tx_busy;
    logic [31:0] pad_state;
    logic        pad_latch;
    logic [7:0]  last_cmd;
    logic [15:0] cmd_count;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;

    int cmd_exp = 0;
    int err_exp = 0;

    n64_command_scheduler #(
        .RESP_DELAY (RD),
        .TX_TIMEOUT (TO)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .rx_trigger   (rx_trigger),
        .rx_receiving (rx_receiving),
        .rx_command   (rx_command),
        .tx_start     (tx_start),
        .tx_len       (tx_len),
        .tx_data      (tx_data),
        .tx_byte_req  (tx_byte_req),
        .tx_busy      (tx_busy),
        .pad_state    (pad_state),
        .pad_latch    (pad_latch),
        .last_cmd     (last_cmd),
        .cmd_count    (cmd_count),
        .err_count    (err_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic err_inc();
        if (err_exp < 255) err_exp++;
    endtask

    task automatic wait_trigger(input string tag);
        int k = 0;
        while (rx_trigger !== 1'b1 && k < 50) begin
            @(negedge sys_clk);
            k++;
        end
        check(tag, {31'd0, rx_trigger}, 32'd1);
    endtask

    // mode: 0 normal handshake, 1 transmitter hangs busy, 2 reset mid-SEND.
    // Entered with rx_trigger visible at the current negedge.
    task automatic run_cmd(input logic [7:0] cmd, input int mode, input bit drop_en);
        logic [7:0] exp_b [4];
        int len;
        int k;
        bit known;
        known = (cmd == 8'h00) || (cmd == 8'h01) || (cmd == 8'hFF);
        if (cmd == 8'h01) begin
            len = 4;
            exp_b[0] = pad_state[31:24];
            exp_b[1] = pad_state[23:16];
            exp_b[2] = pad_state[15:8];
            exp_b[3] = pad_state[7:0];
        end else begin
            len = 3;
            exp_b[0] = 8'h05;
            exp_b[1] = 8'h00;
            exp_b[2] = 8'h02;
            exp_b[3] = 8'h00;
        end

        rx_receiving = 1'b1;
        rx_command   = 8'($urandom);
        @(negedge sys_clk);
        check("trig_pulse", {31'd0, rx_trigger}, 32'd0);
        repeat (1 + $urandom_range(0, 3)) @(negedge sys_clk);
        rx_command   = cmd;
        rx_receiving = 1'b0;
        @(negedge sys_clk);
        check("pad_latch", {31'd0, pad_latch}, {31'd0, (cmd == 8'h01)});
        check("last_cmd", {24'd0, last_cmd}, {24'd0, cmd});

        if (!known) begin
            err_inc();
            @(negedge sys_clk);
            check("rearm_unknown", {31'd0, rx_trigger}, 32'd1);
            check("err_unknown", {24'd0, err_count}, err_exp);
            return;
        end

        k = 0;
        while (tx_start !== 1'b1 && k < 200) begin
            @(negedge sys_clk);
            k++;
            if (drop_en && k == 1) enable = 1'b0;
        end
        check("tx_start_lat", k, RD + 1);
        check("tx_len", {29'd0, tx_len}, len);
        check("byte0", {24'd0, tx_data}, {24'd0, exp_b[0]});
        tx_busy   = 1'b1;
        pad_state = $urandom;

        if (mode == 1) begin
            repeat (TO - 1) @(negedge sys_clk);
            check("err_before_to", {24'd0, err_count}, err_exp);
            @(negedge sys_clk);
            err_inc();
            check("err_timeout", {24'd0, err_count}, err_exp);
            check("cmd_timeout", {16'd0, cmd_count}, cmd_exp);
            tx_busy = 1'b0;
            return;
        end

        if (mode == 2) begin
            repeat (2) @(negedge sys_clk);
            #2 rst_n = 1'b0;
            #1;
            check("rst_outs", {10'd0, rx_trigger, tx_start, tx_len, tx_data, pad_latch, last_cmd},
                  32'd0);
            check("rst_counts", {8'd0, cmd_count, err_count}, 32'd0);
            cmd_exp = 0;
            err_exp = 0;
            tx_busy = 1'b0;
            @(negedge sys_clk);
            check("rst_held", {30'd0, rx_trigger, tx_start}, 32'd0);
            rst_n = 1'b1;
            return;
        end

        for (int i = 1; i < len; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge sys_clk);
            tx_byte_req = 1'b1;
            @(negedge sys_clk);
            tx_byte_req = 1'b0;
            check("byte", {24'd0, tx_data}, {24'd0, exp_b[i]});
        end
        tx_byte_req = 1'b1;
        @(negedge sys_clk);
        tx_byte_req = 1'b0;
        check("idx_sat", {24'd0, tx_data}, {24'd0, exp_b[len-1]});
        tx_busy = 1'b0;
        @(negedge sys_clk);
        cmd_exp = (cmd_exp + 1) % 65536;
        check("cmd_count", {16'd0, cmd_count}, cmd_exp);
        check("err_count", {24'd0, err_count}, err_exp);
    endtask

    function automatic logic [7:0] rand_unknown();
        logic [7:0] c;
        do c = 8'($urandom); while (c == 8'h00 || c == 8'h01 || c == 8'hFF);
        return c;
    endfunction

    initial begin
        int trig_cnt;
        int r;
        rst_n        = 1'b0;
        enable       = 1'b1;
        rx_receiving = 1'b0;
        rx_command   = 8'h00;
        tx_byte_req  = 1'b0;
        tx_busy      = 1'b0;
        pad_state    = 32'h0;
        repeat (3) @(negedge sys_clk);
        check("reset_outs", {10'd0, rx_trigger, tx_start, tx_len, tx_data, pad_latch, last_cmd},
              32'd0);
        check("reset_counts", {8'd0, cmd_count, err_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("first_trigger", {31'd0, rx_trigger}, 32'd1);

        run_cmd(8'h00, 0, 1'b0);
        wait_trigger("trig_after_00");

        pad_state = 32'h8001_7F80;
        run_cmd(8'h01, 0, 1'b0);
        wait_trigger("trig_after_01");

        run_cmd(8'hFF, 1, 1'b0);
        wait_trigger("trig_after_timeout");

        run_cmd(8'h42, 0, 1'b0);
        for (int i = 0; i < 299; i++) run_cmd(rand_unknown(), 0, 1'b0);
        check("err_saturated", {24'd0, err_count}, 32'd255);
        wait_trigger("trig_after_unknown");

        run_cmd(8'h00, 2, 1'b0);
        wait_trigger("trig_after_reset");
        run_cmd(8'hFF, 0, 1'b0);
        wait_trigger("trig_after_ff");

        for (int i = 0; i < 20; i++) begin
            pad_state = $urandom;
            r = $urandom_range(0, 3);
            case (r)
                0:       run_cmd(8'h00, 0, 1'b0);
                1:       run_cmd(8'hFF, 0, 1'b0);
                2:       run_cmd(8'h01, 0, 1'b0);
                default: run_cmd(rand_unknown(), 0, 1'b0);
            endcase
            wait_trigger("trig_mix");
        end

        run_cmd(8'h01, 0, 1'b1);
        trig_cnt = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (rx_trigger === 1'b1) trig_cnt++;
        end
        check("parked_no_trigger", trig_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
